ram_dual_arb: RTL and testbench



---
 rtl/ram_dual_arb.sv | 148 ++++++++++++++
 tb/tb_ram_dual_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dual_arb.sv
// ram_dual_arb
//   Shares both ports of the dual-port coefficient RAM (1-cycle registered
//   read, write-first q) among NREQ requesters. Up to two requests are
//   accepted per cycle, one per RAM port, and every read result is routed
//   back to its requester with a one-cycle valid strobe.
//
// Build option
//   RAM_ARB_FIXED_PRI_EN : search always starts at requester 0 (fixed
//                          priority, no round-robin pointer). Undefined
//                          (default) gives round-robin arbitration.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   req/req_we            per-requester request and write flag, held until gnt
//   req_addr/req_data     packed per-requester operands (slice i)
//   gnt                   combinational accept strobe
//   rvalid/rdata          read return; rdata slice holds until the next read
//   address_x/data_x/wren_x  to RAM port x (zero when the port is idle)
//   q_0/q_1               RAM read data, one cycle after the access

module ram_dual_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int NREQ  = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [NREQ*WIDTH-1:0] rdata,
  output logic [AW-1:0]         address_0,
  output logic [WIDTH-1:0]      data_0,
  output logic                  wren_0,
  input  logic [WIDTH-1:0]      q_0,
  output logic [AW-1:0]         address_1,
  output logic [WIDTH-1:0]      data_1,
  output logic                  wren_1,
  input  logic [WIDTH-1:0]      q_1
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [AW-1:0]    w_addr [NREQ];
  logic [WIDTH-1:0] w_data [NREQ];
  logic [WIDTH-1:0] w_q    [NREQ];
  logic [IW-1:0]    w_start;
  logic [IW:0]      w_sum;
  logic [IW-1:0]    w_idx;
  logic             w_v0, w_v1;
  logic [IW-1:0]    w_i0, w_i1;
  logic [NREQ-1:0]  w_gnt;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr[g*AW +: AW];
    assign w_data[g] = req_data[g*WIDTH +: WIDTH];
  end

`ifdef RAM_ARB_FIXED_PRI_EN
  assign w_start = '0;
`else
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_last;

  assign w_last  = w_v1 ? w_i1 : w_i0;
  assign w_start = r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_v0) begin
      r_ptr <= (w_last == IW'(NREQ-1)) ? '0 : w_last + 1'b1;
    end
  end
`endif

  // Circular search from w_start: the first requester takes port 0, the next
  // one that does not collide with it takes port 1. A collision is the same
  // address with at least one write; two reads of one address may pair up.
  always_comb begin
    w_v0  = 1'b0;
    w_v1  = 1'b0;
    w_i0  = '0;
    w_i1  = '0;
    w_sum = '0;
    w_idx = '0;
    w_gnt = '0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        w_sum = {1'b0, w_start} + (IW+1)'(k);
        if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
        w_idx = w_sum[IW-1:0];
        if (req[w_idx]) begin
          if (!w_v0) begin
            w_v0 = 1'b1;
            w_i0 = w_idx;
          end else if (!w_v1 &&
                       !((w_addr[w_idx] == w_addr[w_i0]) &&
                         (req_we[w_idx] || req_we[w_i0]))) begin
            w_v1 = 1'b1;
            w_i1 = w_idx;
          end
        end
      end
      if (w_v0) w_gnt[w_i0] = 1'b1;
      if (w_v1) w_gnt[w_i1] = 1'b1;
    end
  end

  assign gnt       = w_gnt;
  assign address_0 = w_v0 ? w_addr[w_i0] : '0;
  assign data_0    = w_v0 ? w_data[w_i0] : '0;
  assign wren_0    = w_v0 & req_we[w_i0];
  assign address_1 = w_v1 ? w_addr[w_i1] : '0;
  assign data_1    = w_v1 ? w_data[w_i1] : '0;
  assign wren_1    = w_v1 & req_we[w_i1];

  // Read return: remember which port served each requester's read, then
  // pass that port's q straight through during the valid cycle and keep a
  // copy so the slice holds afterwards. Reset drops anything in flight.
  logic             r_rvalid [NREQ];
  logic             r_rport  [NREQ];
  logic [WIDTH-1:0] r_rdata  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_ret
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rvalid[g] <= 1'b0;
        r_rport[g]  <= 1'b0;
        r_rdata[g]  <= '0;
      end else begin
        r_rvalid[g] <= w_gnt[g] & ~req_we[g];
        if (w_gnt[g]) r_rport[g] <= w_v1 && (w_i1 == IW'(g));
        if (r_rvalid[g]) r_rdata[g] <= w_q[g];
      end
    end

    assign w_q[g]                  = r_rport[g] ? q_1 : q_0;
    assign rvalid[g]               = r_rvalid[g] & ~rst;
    assign rdata[g*WIDTH +: WIDTH] = rvalid[g] ? w_q[g] : r_rdata[g];
  end

endmodule

// File: tb/tb_ram_dual_arb.sv
// Bench for ram_dual_arb: a behavioural dual-port RAM, directed scenarios
// and a randomized phase, all checked against a queue-based arbitration
// model with its own memory image.
module tb_ram_dual_arb;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int NREQ  = 4;
  localparam int AW    = 6;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [NREQ*WIDTH-1:0] rdata;
  logic [AW-1:0]         address_0, address_1;
  logic [WIDTH-1:0]      data_0, data_1, q_0, q_1;
  logic                  wren_0, wren_1;

  ram_dual_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .address_0(address_0), .data_0(data_0), .wren_0(wren_0), .q_0(q_0),
    .address_1(address_1), .data_1(data_1), .wren_1(wren_1), .q_1(q_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus arrays, packed onto the DUT ports
  bit              t_req  [NREQ];
  bit              t_we   [NREQ];
  logic [AW-1:0]   t_addr [NREQ];
  logic [WIDTH-1:0] t_data [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req[g]                     = t_req[g];
    assign req_we[g]                  = t_we[g];
    assign req_addr[g*AW +: AW]       = t_addr[g];
    assign req_data[g*WIDTH +: WIDTH] = t_data[g];
  end

  function automatic logic [7:0] init_val(int a);
    return 8'(a * 37 + 11);
  endfunction

  // behavioural RAM: registered read, write-first
  logic [WIDTH-1:0] ram [DEPTH];
  logic             tb_init;
  always @(posedge clk) begin
    if (tb_init) begin
      for (int a = 0; a < DEPTH; a++) ram[a] <= init_val(a);
    end else begin
      if (wren_0) ram[address_0] <= data_0;
      if (wren_1) ram[address_1] <= data_1;
    end
    q_0 <= wren_0 ? data_0 : ram[address_0];
    q_1 <= wren_1 ? data_1 : ram[address_1];
  end

  // reference model state
  logic [7:0] mdl_mem [DEPTH];
  int         m_ptr;
  bit         e_rv     [NREQ];
  logic [7:0] e_data   [NREQ];
  logic [7:0] e_shadow [NREQ];
  logic [3:0] m_gnt;

  // sampled DUT outputs of the last step
  logic [3:0]  s_gnt, s_rvalid;
  logic [31:0] s_rdata;
  logic        s_wren0, s_wren1;
  logic [5:0]  s_addr1;

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input bit we, input int addr, input int data);
    t_req[i]  = 1'b1;
    t_we[i]   = we;
    t_addr[i] = 6'(addr);
    t_data[i] = 8'(data);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) t_req[i] = 1'b0;
  endtask

  // One clock: sample at negedge, compare with the model, advance the model.
  task automatic step();
    int         ord[$];
    int         p0, p1, start, last;
    logic [3:0] eg, erv;
    logic [31:0] erd;
    logic [5:0] ea0, ea1;
    logic [7:0] ed0, ed1;
    bit         ew0, ew1;
    bit         nrv [NREQ];
    logic [7:0] ndat [NREQ];

    @(negedge clk);
    s_gnt    = gnt;
    s_rvalid = rvalid;
    s_rdata  = rdata;
    s_wren0  = wren_0;
    s_wren1  = wren_1;
    s_addr1  = address_1;

    p0 = -1;
    p1 = -1;
    if (!rst) begin
`ifdef RAM_ARB_FIXED_PRI_EN
      start = 0;
`else
      start = m_ptr;
`endif
      for (int k = 0; k < NREQ; k++) ord.push_back((start + k) % NREQ);
      for (int j = 0; j < ord.size(); j++) begin
        int c;
        c = ord[j];
        if (t_req[c]) begin
          if (p0 < 0) p0 = c;
          else if (p1 < 0 && !(t_addr[c] == t_addr[p0] && (t_we[c] || t_we[p0])))
            p1 = c;
        end
      end
    end

    eg = 4'b0;
    if (p0 >= 0) eg = eg | (4'b1 << p0);
    if (p1 >= 0) eg = eg | (4'b1 << p1);
    ea0 = (p0 >= 0) ? t_addr[p0] : 6'd0;
    ed0 = (p0 >= 0) ? t_data[p0] : 8'd0;
    ew0 = (p0 >= 0) && t_we[p0];
    ea1 = (p1 >= 0) ? t_addr[p1] : 6'd0;
    ed1 = (p1 >= 0) ? t_data[p1] : 8'd0;
    ew1 = (p1 >= 0) && t_we[p1];

    erv = 4'b0;
    erd = 32'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (e_rv[i] && !rst) erv = erv | (4'b1 << i);
      erd = erd | (32'(((e_rv[i] && !rst) ? e_data[i] : e_shadow[i])) << (8 * i));
    end

    check("gnt",       64'(gnt),       64'(eg));
    check("rvalid",    64'(rvalid),    64'(erv));
    check("rdata",     64'(rdata),     64'(erd));
    check("wren_0",    64'(wren_0),    64'(ew0));
    check("wren_1",    64'(wren_1),    64'(ew1));
    check("address_0", 64'(address_0), 64'(ea0));
    check("address_1", 64'(address_1), 64'(ea1));
    check("data_0",    64'(data_0),    64'(ed0));
    check("data_1",    64'(data_1),    64'(ed1));

    for (int i = 0; i < NREQ; i++) begin
      if (rst) e_shadow[i] = 8'd0;
      else if (e_rv[i]) e_shadow[i] = e_data[i];
      nrv[i]  = 1'b0;
      ndat[i] = 8'd0;
    end
    if (p0 >= 0 && !t_we[p0]) begin nrv[p0] = 1'b1; ndat[p0] = mdl_mem[t_addr[p0]]; end
    if (p1 >= 0 && !t_we[p1]) begin nrv[p1] = 1'b1; ndat[p1] = mdl_mem[t_addr[p1]]; end
    if (ew0) mdl_mem[ea0] = ed0;
    if (ew1) mdl_mem[ea1] = ed1;
    for (int i = 0; i < NREQ; i++) begin
      e_rv[i]   = nrv[i];
      e_data[i] = ndat[i];
    end
    if (rst) m_ptr = 0;
    else if (p0 >= 0) begin
      last  = (p1 >= 0) ? p1 : p0;
      m_ptr = (last + 1) % NREQ;
    end
    m_gnt = eg;

    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    tb_init = 1'b1;
    m_ptr   = 0;
    m_gnt   = 4'b0;
    for (int i = 0; i < NREQ; i++) begin
      t_req[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = '0; t_data[i] = '0;
      e_rv[i] = 1'b0; e_data[i] = '0; e_shadow[i] = '0;
    end
    for (int a = 0; a < DEPTH; a++) mdl_mem[a] = init_val(a);
    repeat (3) @(posedge clk);
    #1;
    tb_init = 1'b0;

    // reset state; a pending write under reset must not reach the RAM
    set_op(0, 1'b1, 4, 8'hEE);
    set_op(2, 1'b1, 4, 8'hDD);
    step();
    check("rst_gnt",    64'(s_gnt),    64'(0));
    check("rst_wren0",  64'(s_wren0),  64'(0));
    check("rst_rvalid", 64'(s_rvalid), 64'(0));
    check("rst_rdata",  64'(s_rdata),  64'(0));
    clear_reqs();
    rst = 1'b0;
    step();
    check("rst_nowrite", 64'(ram[4]), 64'(init_val(4)));

    // single read of a freshly written word
    set_op(2, 1'b1, 5, 8'h3C);
    step();
    clear_reqs();
    set_op(2, 1'b0, 5, 0);
    step();
    check("single_gnt", 64'(s_gnt), 64'(4'b0100));
    clear_reqs();
    step();
    check("single_rvalid", 64'(s_rvalid), 64'(4'b0100));
    check("single_rdata",  64'(s_rdata[23:16]), 64'(8'h3C));

    // write on port 0 and read on port 1 in one cycle
    set_op(0, 1'b1, 1, 8'hAA);
    set_op(1, 1'b0, 2, 0);
    step();
    check("dual_gnt",   64'(s_gnt),   64'(4'b0011));
    check("dual_wren0", 64'(s_wren0), 64'(1));
    check("dual_addr1", 64'(s_addr1), 64'(2));
    clear_reqs();

    // two writes to the same address serialize
    set_op(0, 1'b1, 7, 8'h11);
    set_op(1, 1'b1, 7, 8'h22);
    step();
    check("wconf_gnt_a", 64'(s_gnt), 64'(4'b0001));
    t_req[0] = 1'b0;
    step();
    check("wconf_gnt_b", 64'(s_gnt), 64'(4'b0010));
    check("wconf_wren1", 64'(s_wren1), 64'(0));
    clear_reqs();
    step();
    check("wconf_ram", 64'(ram[7]), 64'(8'h22));

    // two reads of one address pair up
    set_op(0, 1'b0, 9, 0);
    set_op(3, 1'b0, 9, 0);
    step();
    check("same_gnt", 64'(s_gnt), 64'(4'b1001));
    clear_reqs();
    step();
    check("same_rvalid", 64'(s_rvalid), 64'(4'b1001));
    check("same_rd0", 64'(s_rdata[7:0]),   64'(init_val(9)));
    check("same_rd3", 64'(s_rdata[31:24]), 64'(init_val(9)));

    // reset the cycle after a read grant, with a write held during reset
    set_op(2, 1'b0, 20, 0);
    step();
    check("rmid_gnt", 64'(s_gnt), 64'(4'b0100));
    clear_reqs();
    set_op(1, 1'b1, 3, 8'h55);
    rst = 1'b1;
    step();
    check("rmid_rvalid", 64'(s_rvalid), 64'(0));
    check("rmid_gnt0",   64'(s_gnt),    64'(0));
    check("rmid_wren",   64'({s_wren0, s_wren1}), 64'(0));
    clear_reqs();
    rst = 1'b0;
    step();
    check("rmid_after", 64'(s_rvalid), 64'(0));

    // fairness with all four requesters reading
    for (int i = 0; i < NREQ; i++) set_op(i, 1'b0, 10 + i, 0);
    for (int c = 0; c < 4; c++) begin
      step();
`ifdef RAM_ARB_FIXED_PRI_EN
      check("fair_gnt", 64'(s_gnt), 64'(4'b0011));
`else
      check("fair_gnt", 64'(s_gnt), (c % 2 == 0) ? 64'(4'b0011) : 64'(4'b1100));
`endif
    end
    clear_reqs();
    step();

    // randomized traffic with small address range to provoke conflicts
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i]) t_req[i] = 1'b0;
        if (!t_req[i] && $urandom_range(0, 9) < 5)
          set_op(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)));
      end
      step();
    end
    rst = 1'b0;
    clear_reqs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
